// File: rtl/demux_rr_lanes.sv
// demux_rr_lanes: 1-to-LANES round-robin demultiplexer with per-lane holding
// registers and valid/ready handshakes. The lane pointer returns to lane 0
// after IDLE_RST idle input cycles.
// Optional feature macro: DEMUX_RR_STALL_CNT_EN adds a saturating 8-bit
// stall counter output (stall_cnt).
module demux_rr_lanes #(
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int IDLE_RST = 1,
  localparam int SEL_W   = $clog2(LANES)
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  output logic                    ready_in,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        valid_out,
  input  logic [LANES-1:0]        ready_out,
  output logic [SEL_W-1:0]        lane_sel
`ifdef DEMUX_RR_STALL_CNT_EN
  ,
  output logic [7:0]              stall_cnt
`endif
);

  localparam int IDLE_W = (IDLE_RST < 1) ? 1 : $clog2(IDLE_RST + 1);
  localparam logic [SEL_W-1:0]  LAST_LANE = SEL_W'(LANES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_RST);

  typedef enum logic {
    ALIGNED = 1'b0,
    FILLING = 1'b1
  } state_t;

  state_t                   r_state;
  logic [SEL_W-1:0]         r_ptr;
  logic [IDLE_W-1:0]        r_idleCnt;
  logic [LANES*DATA_W-1:0]  r_dataOut;
  logic [LANES-1:0]         r_validOut;

  logic                     w_readyIn;
  logic                     w_accept;
  logic [IDLE_W-1:0]        w_idleNext;
  logic                     w_realign;
  logic [SEL_W-1:0]         w_ptrInc;

  // Handshake toward the un-striper: the current lane can take a word if it is
  // empty or is being emptied by its consumer this cycle.
  always_comb begin
    w_readyIn = !r_validOut[r_ptr] || ready_out[r_ptr];
    w_accept  = valid_in && w_readyIn;
    w_ptrInc  = (r_ptr == LAST_LANE) ? '0 : r_ptr + 1'b1;
  end

  // Next idle count and the re-alignment decision; re-alignment happens on the
  // edge where the count reaches the threshold, so the next word goes to lane 0.
  always_comb begin
    w_idleNext = r_idleCnt;
    if (valid_in) begin
      w_idleNext = '0;
    end else if (r_idleCnt != IDLE_MAX) begin
      w_idleNext = r_idleCnt + 1'b1;
    end
    w_realign = (IDLE_RST != 0) && !valid_in && (w_idleNext == IDLE_MAX) &&
                (r_state == FILLING);
  end

  // Group FSM: tracks whether a group is in progress and owns the lane pointer
  // and the idle counter. An accept always takes priority over re-alignment.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_state   <= ALIGNED;
      r_ptr     <= '0;
      r_idleCnt <= '0;
    end else begin
      r_idleCnt <= w_idleNext;
      if (w_accept) begin
        r_ptr   <= w_ptrInc;
        r_state <= (r_ptr == LAST_LANE) ? ALIGNED : FILLING;
      end else if (w_realign) begin
        r_ptr   <= '0;
        r_state <= ALIGNED;
      end
    end
  end

  // Lane holding registers: a load beats a drain on the same lane, and data is
  // kept (not cleared) when a lane drains.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_dataOut  <= '0;
      r_validOut <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_accept && (r_ptr == SEL_W'(i))) begin
          r_dataOut[i*DATA_W +: DATA_W] <= data_in;
          r_validOut[i]                 <= 1'b1;
        end else if (r_validOut[i] && ready_out[i]) begin
          r_validOut[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_RR_STALL_CNT_EN
  logic [7:0] r_stallCnt;

  // Saturating count of cycles where upstream offered a word we could not take.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_stallCnt <= '0;
    end else if (valid_in && !w_readyIn && (r_stallCnt != 8'hFF)) begin
      r_stallCnt <= r_stallCnt + 8'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
`endif

  assign ready_in  = w_readyIn;
  assign data_out  = r_dataOut;
  assign valid_out = r_validOut;
  assign lane_sel  = r_ptr;

endmodule
